// File: rtl/bp_be_regfile_mport.sv
// Multi-port register file (integer or FP) with held read addresses, write forwarding and a config port.
// Latency: reads and config reads return one cycle after the address is effective; writes commit at the edge.
// Backpressure: none; a stall is expressed by dropping r_v_i, which holds the address and keeps re-reading.
module bp_be_regfile_mport #(
  parameter int data_width_p  = 64,
  parameter int els_p         = 32,
  parameter int read_ports_p  = 2,
  parameter int write_ports_p = 1,
  parameter bit zero_x0_p     = 1'b1,
  parameter int addr_width_lp = $clog2(els_p)
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic [write_ports_p-1:0]                w_v_i,
  input  logic [write_ports_p*addr_width_lp-1:0]  w_addr_i,
  input  logic [write_ports_p*data_width_p-1:0]   w_data_i,
  input  logic [read_ports_p-1:0]                 r_v_i,
  input  logic [read_ports_p*addr_width_lp-1:0]   r_addr_i,
  output logic [read_ports_p*data_width_p-1:0]    r_data_o,
  input  logic                                    cfg_w_v_i,
  input  logic                                    cfg_r_v_i,
  input  logic [addr_width_lp-1:0]                cfg_addr_i,
  input  logic [data_width_p-1:0]                 cfg_data_i,
  output logic [data_width_p-1:0]                 cfg_data_o
);

  localparam int A = addr_width_lp;
  localparam int D = data_width_p;
  // The config read shares the forwarding path as an extra "port" at the top index.
  localparam int n_rd_lp = read_ports_p + 1;

  logic [D-1:0]       r_mem      [els_p];
  logic [A-1:0]       r_addr     [read_ports_p];
  logic [D-1:0]       r_rdata    [read_ports_p];
  logic [D-1:0]       r_cfg_data;

  logic [els_p-1:0]   w_we;
  logic [D-1:0]       w_wdata    [els_p];
  logic [A-1:0]       w_eff_addr [n_rd_lp];
  logic [D-1:0]       w_fwd_data [n_rd_lp];

  // Per-register write enable/data: later write ports override earlier ones, config overrides all.
  always_comb begin
    for (int g = 0; g < els_p; g++) begin
      w_we[g]    = 1'b0;
      w_wdata[g] = '0;
      for (int j = 0; j < write_ports_p; j++) begin
        if (w_v_i[j] && (w_addr_i[j*A +: A] == A'(g))) begin
          w_we[g]    = 1'b1;
          w_wdata[g] = w_data_i[j*D +: D];
        end
      end
      if (cfg_w_v_i && (cfg_addr_i == A'(g))) begin
        w_we[g]    = 1'b1;
        w_wdata[g] = cfg_data_i;
      end
      if (zero_x0_p && (g == 0)) begin
        w_we[g] = 1'b0;
      end
    end
  end

  for (genvar gr = 0; gr < els_p; gr++) begin : g_reg
    // Storage cell: cleared by reset, otherwise takes the resolved write.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        r_mem[gr] <= '0;
      end else if (w_we[gr]) begin
        r_mem[gr] <= w_wdata[gr];
      end
    end
  end

  // Effective address: a fresh issue bypasses the held address.
  always_comb begin
    for (int i = 0; i < read_ports_p; i++) begin
      w_eff_addr[i] = r_v_i[i] ? r_addr_i[i*A +: A] : r_addr[i];
    end
    w_eff_addr[read_ports_p] = cfg_addr_i;
  end

  // Read with same-cycle forwarding, same priority as the storage update; x0 always reads zero.
  always_comb begin
    for (int i = 0; i < n_rd_lp; i++) begin
      w_fwd_data[i] = r_mem[w_eff_addr[i]];
      for (int j = 0; j < write_ports_p; j++) begin
        if (w_v_i[j] && (w_addr_i[j*A +: A] == w_eff_addr[i])) begin
          w_fwd_data[i] = w_data_i[j*D +: D];
        end
      end
      if (cfg_w_v_i && (cfg_addr_i == w_eff_addr[i])) begin
        w_fwd_data[i] = cfg_data_i;
      end
      if (zero_x0_p && (w_eff_addr[i] == '0)) begin
        w_fwd_data[i] = '0;
      end
    end
  end

  for (genvar gp = 0; gp < read_ports_p; gp++) begin : g_rd
    // Held address and registered read data; re-read every cycle so stalls see new writes.
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        r_addr[gp]  <= '0;
        r_rdata[gp] <= '0;
      end else begin
        r_addr[gp]  <= w_eff_addr[gp];
        r_rdata[gp] <= w_fwd_data[gp];
      end
    end
    assign r_data_o[gp*D +: D] = r_rdata[gp];
  end

  // Config read data: updates only on a config read, otherwise holds.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cfg_data <= '0;
    end else if (cfg_r_v_i) begin
      r_cfg_data <= w_fwd_data[read_ports_p];
    end
  end

  assign cfg_data_o = r_cfg_data;

  // Simulation-only checks: address range and disagreeing write ports.
  always @(posedge clk_i) begin
    if (!reset_i) begin
      for (int j = 0; j < write_ports_p; j++) begin
        if (w_v_i[j]) begin
          assert (32'(w_addr_i[j*A +: A]) < els_p)
            else $error("write port %0d address %0d out of range", j, w_addr_i[j*A +: A]);
        end
        for (int k = j + 1; k < write_ports_p; k++) begin
          if (w_v_i[j] && w_v_i[k] && (w_addr_i[j*A +: A] == w_addr_i[k*A +: A])) begin
            assert (w_data_i[j*D +: D] == w_data_i[k*D +: D])
              else $warning("write ports %0d and %0d disagree on address %0d", j, k, w_addr_i[j*A +: A]);
          end
        end
      end
      for (int i = 0; i < read_ports_p; i++) begin
        if (r_v_i[i]) begin
          assert (32'(r_addr_i[i*A +: A]) < els_p)
            else $error("read port %0d address %0d out of range", i, r_addr_i[i*A +: A]);
        end
      end
      if (cfg_w_v_i || cfg_r_v_i) begin
        assert (32'(cfg_addr_i) < els_p)
          else $error("config address %0d out of range", cfg_addr_i);
      end
    end
  end

endmodule
